// File: rtl/seven_seg_pkg.sv
// Shared constants and types for the multiplexed seven-segment display driver.
// Segment codes are active-high with bit 0 = a through bit 6 = g.
package seven_seg_pkg;

  localparam int MAX_DIGITS = 8;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [6:0] SEG_DARK_N = 7'h7F;

  // Standard hex font: 0-9, A, b, C, d, E, F
  localparam logic [6:0] FONT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // One display snapshot, sized for the largest supported digit count
  typedef struct packed {
    logic [MAX_DIGITS-1:0][3:0] digits;
    logic [MAX_DIGITS-1:0]      dp;
    logic [MAX_DIGITS-1:0]      blank;
    logic                       lzEn;
  } dispState_t;

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational hex nibble to active-high segment decoder.
module seven_seg_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = FONT[nibble_i];

endmodule

// File: rtl/seven_seg_mux.sv
// Time-multiplexed seven-segment driver with dead time between digits and
// frame-synchronous double buffering so a frame never mixes old and new digits.
module seven_seg_mux
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    lz_en,
  input  logic                    load,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_done
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_DEAD = CNT_W'(DEAD_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]      prescale_q, prescale_d;
  logic [IDX_W-1:0]      digitIdx_q, digitIdx_d;
  dispState_t            shadow_q, shadow_d;
  dispState_t            active_q, active_d;
  dispState_t            loadState;
  logic                  pending_q, pending_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  slotEnd, frameEnd;
  logic [2:0]            selIdx;
  logic [3:0]            selNibble;
  logic [6:0]            selSegs;
  logic                  selBlank;
  logic                  zeroAbove;
  logic [MAX_DIGITS-1:0] lzSuppress;

  assign slotEnd    = (prescale_q == CNT_LAST);
  assign frameEnd   = slotEnd && (digitIdx_q == IDX_LAST);
  assign frame_done = frameEnd;

  always_comb begin
    prescale_d = slotEnd ? '0 : prescale_q + 1'b1;
    digitIdx_d = digitIdx_q;
    if (slotEnd) begin
      digitIdx_d = (digitIdx_q == IDX_LAST) ? '0 : digitIdx_q + 1'b1;
    end
  end

  // A load landing on the frame boundary goes straight to the active copy
  always_comb begin
    loadState                          = '0;
    loadState.digits[NUM_DIGITS-1:0]   = digits_in;
    loadState.dp[NUM_DIGITS-1:0]       = dp_in;
    loadState.blank[NUM_DIGITS-1:0]    = blank_in;
    loadState.lzEn                     = lz_en;

    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (frameEnd) begin
      if (load) begin
        active_d  = loadState;
        pending_d = 1'b0;
      end else if (pending_q) begin
        active_d  = shadow_q;
        pending_d = 1'b0;
      end
    end else if (load) begin
      shadow_d  = loadState;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescale_q <= '0;
      digitIdx_q <= '0;
      shadow_q   <= '0;
      active_q   <= '0;
      pending_q  <= 1'b0;
      seg_q      <= SEG_DARK_N;
      dp_q       <= 1'b1;
    end else begin
      prescale_q <= prescale_d;
      digitIdx_q <= digitIdx_d;
      shadow_q   <= shadow_d;
      active_q   <= active_d;
      pending_q  <= pending_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
    end
  end

  // Zero digits above the most significant non-zero one go dark; digit 0 never does
  always_comb begin
    lzSuppress = '0;
    zeroAbove  = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zeroAbove     = zeroAbove && (active_q.digits[i] == 4'h0);
      lzSuppress[i] = active_q.lzEn && zeroAbove;
    end
  end

  assign selIdx    = 3'(digitIdx_q);
  assign selNibble = active_q.digits[selIdx];
  assign selBlank  = active_q.blank[selIdx] || lzSuppress[selIdx];

  seven_seg_decode u_decode (
    .nibble_i (selNibble),
    .seg_o    (selSegs)
  );

  always_comb begin
    seg_d = selBlank ? SEG_DARK_N : ~selSegs;
    dp_d  = ~active_q.dp[selIdx];
  end

  always_comb begin
    an_n = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      an_n[i] = !((prescale_q >= CNT_DEAD) && (digitIdx_q == IDX_W'(i)));
    end
  end

  assign seg_n = seg_q;
  assign dp_n  = dp_q;

endmodule

// File: tb/tb_seven_seg_mux.sv
// Self-checking bench for seven_seg_mux against a cycle-count based display model.
module tb_seven_seg_mux;

  localparam int ND    = 4;
  localparam int RD    = 8;
  localparam int DC    = 2;
  localparam int FRAME = ND * RD;

  localparam logic [6:0] FONT_HI [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] digits_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank_in = '0;
  logic        lz_en = 1'b0;
  logic        load = 1'b0;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  an_n;
  logic        frame_done;

  seven_seg_mux #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD),
    .DEAD_CYCLES (DC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .digits_in  (digits_in),
    .dp_in      (dp_in),
    .blank_in   (blank_in),
    .lz_en      (lz_en),
    .load       (load),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .an_n       (an_n),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int testsRun  = 0;
  int failCount = 0;

  // Model: cycles since reset release, plus displayed and buffered content
  int          t;
  logic [15:0] actDig, shDig;
  logic [3:0]  actDp, shDp, actBlank, shBlank;
  bit          actLz, shLz, pending;
  logic [6:0]  expSeg;
  logic        expDp;

  function automatic logic [3:0] expAn();
    int pres = t % RD;
    int idx  = (t / RD) % ND;
    return (pres < DC) ? 4'hF : ~(4'b0001 << idx);
  endfunction

  function automatic logic expFd();
    return (t % FRAME) == FRAME - 1;
  endfunction

  function automatic logic [6:0] segFor(int k);
    bit suppressed = actLz && (k > 0);
    for (int j = k; j < ND; j++) begin
      if (actDig[4*j +: 4] != 4'h0) suppressed = 0;
    end
    if (actBlank[k] || suppressed) return 7'h7F;
    return ~FONT_HI[actDig[4*k +: 4]];
  endfunction

  task automatic resetModel();
    t = 0;
    actDig = '0; actDp = '0; actBlank = '0; actLz = 0;
    shDig = '0; shDp = '0; shBlank = '0; shLz = 0;
    pending = 0;
    expSeg = 7'h7F;
    expDp = 1'b1;
  endtask

  // One clock: drive inputs at the falling edge, update the model on the rising edge
  task automatic tick(input bit doLoad, input logic [15:0] dig, input logic [3:0] dp,
                      input logic [3:0] bl, input bit lz);
    int         idx = (t / RD) % ND;
    logic [6:0] s = segFor(idx);
    logic       d = ~actDp[idx];
    bit         boundary = (t % FRAME) == FRAME - 1;
    load = doLoad;
    if (doLoad) begin
      digits_in = dig; dp_in = dp; blank_in = bl; lz_en = lz;
    end
    @(posedge clk);
    if (doLoad && boundary) begin
      actDig = dig; actDp = dp; actBlank = bl; actLz = lz; pending = 0;
    end else if (doLoad) begin
      shDig = dig; shDp = dp; shBlank = bl; shLz = lz; pending = 1;
    end else if (boundary && pending) begin
      actDig = shDig; actDp = shDp; actBlank = shBlank; actLz = shLz; pending = 0;
    end
    t++;
    expSeg = s;
    expDp = d;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    resetModel();
    repeat (3) @(posedge clk);
    @(negedge clk);
    testsRun++;
    if (an_n !== 4'hF) begin
      failCount++; $display("[TB] FAIL reset_an got %b want 1111", an_n);
    end
    testsRun++;
    if (seg_n !== 7'h7F) begin
      failCount++; $display("[TB] FAIL reset_seg got %h want 7f", seg_n);
    end
    testsRun++;
    if (dp_n !== 1'b1) begin
      failCount++; $display("[TB] FAIL reset_dp got %b want 1", dp_n);
    end
    testsRun++;
    if (frame_done !== 1'b0) begin
      failCount++; $display("[TB] FAIL reset_fd got %b want 0", frame_done);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_scan_idle();
    for (int c = 0; c < 2 * FRAME; c++) begin
      tick(0, '0, '0, '0, 0);
      testsRun++;
      if (an_n !== expAn() || seg_n !== expSeg || dp_n !== expDp || frame_done !== expFd()) begin
        failCount++;
        $display("[TB] FAIL scan_idle t=%0d got an=%b seg=%h dp=%b fd=%b want an=%b seg=%h dp=%b fd=%b",
                 t, an_n, seg_n, dp_n, frame_done, expAn(), expSeg, expDp, expFd());
      end
      if ((t % RD) >= DC) begin
        testsRun++;
        if (seg_n !== 7'h40) begin
          failCount++; $display("[TB] FAIL scan_idle_zero t=%0d got %h want 40", t, seg_n);
        end
      end
    end
  endtask

  task automatic test_load_hex();
    logic [6:0] obs [ND];
    logic       obsDp [ND];
    logic [6:0] want [ND] = '{7'h0E, 7'h08, 7'h24, 7'h79};
    logic       wantDp [ND] = '{1'b1, 1'b1, 1'b0, 1'b1};
    int         loadFrame = -10;
    for (int k = 0; k < ND; k++) begin obs[k] = 'x; obsDp[k] = 'x; end
    for (int c = 0; c < 3 * FRAME; c++) begin
      if (c == 5) loadFrame = t / FRAME;
      tick(c == 5, 16'h12AF, 4'b0100, 4'b0000, 0);
      testsRun++;
      if (an_n !== expAn() || seg_n !== expSeg || dp_n !== expDp || frame_done !== expFd()) begin
        failCount++;
        $display("[TB] FAIL load_hex t=%0d got an=%b seg=%h dp=%b fd=%b want an=%b seg=%h dp=%b fd=%b",
                 t, an_n, seg_n, dp_n, frame_done, expAn(), expSeg, expDp, expFd());
      end
      if (t / FRAME == loadFrame + 1 && t % RD == 4) begin
        obs[(t / RD) % ND] = seg_n;
        obsDp[(t / RD) % ND] = dp_n;
      end
    end
    for (int k = 0; k < ND; k++) begin
      testsRun++;
      if (obs[k] !== want[k] || obsDp[k] !== wantDp[k]) begin
        failCount++;
        $display("[TB] FAIL load_hex_digit%0d got seg=%h dp=%b want seg=%h dp=%b",
                 k, obs[k], obsDp[k], want[k], wantDp[k]);
      end
    end
  endtask

  task automatic test_lz();
    logic [6:0] obs [ND];
    logic [6:0] want [ND] = '{7'h40, 7'h78, 7'h7F, 7'h7F};
    int         loadFrame = -10;
    for (int k = 0; k < ND; k++) obs[k] = 'x;
    for (int c = 0; c < 3 * FRAME; c++) begin
      if (c == 9) loadFrame = t / FRAME;
      tick(c == 9, 16'h0070, 4'b0000, 4'b0000, 1);
      testsRun++;
      if (an_n !== expAn() || seg_n !== expSeg || dp_n !== expDp || frame_done !== expFd()) begin
        failCount++;
        $display("[TB] FAIL lz t=%0d got an=%b seg=%h dp=%b fd=%b want an=%b seg=%h dp=%b fd=%b",
                 t, an_n, seg_n, dp_n, frame_done, expAn(), expSeg, expDp, expFd());
      end
      if (t / FRAME == loadFrame + 1 && t % RD == 4) obs[(t / RD) % ND] = seg_n;
    end
    for (int k = 0; k < ND; k++) begin
      testsRun++;
      if (obs[k] !== want[k]) begin
        failCount++; $display("[TB] FAIL lz_digit%0d got %h want %h", k, obs[k], want[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] obs [ND];
    int         loadFrame = -10;
    int         seenOnes = 0;
    bit         first = 0, second = 0;
    bit         doLoad;
    logic [15:0] val;
    for (int k = 0; k < ND; k++) obs[k] = 'x;
    for (int c = 0; c < 4 * FRAME; c++) begin
      doLoad = 0;
      val = 16'h0000;
      if (!first && t % FRAME == 4) begin
        doLoad = 1; val = 16'h1111; first = 1;
      end else if (first && !second && t % FRAME == 20) begin
        doLoad = 1; val = 16'h2222; second = 1; loadFrame = t / FRAME;
      end
      tick(doLoad, val, 4'b0000, 4'b0000, 0);
      testsRun++;
      if (an_n !== expAn() || seg_n !== expSeg || dp_n !== expDp || frame_done !== expFd()) begin
        failCount++;
        $display("[TB] FAIL back_to_back t=%0d got an=%b seg=%h dp=%b fd=%b want an=%b seg=%h dp=%b fd=%b",
                 t, an_n, seg_n, dp_n, frame_done, expAn(), expSeg, expDp, expFd());
      end
      if (an_n !== 4'hF && seg_n === 7'h79) seenOnes++;
      if (t / FRAME == loadFrame + 1 && t % RD == 4) obs[(t / RD) % ND] = seg_n;
    end
    testsRun++;
    if (seenOnes !== 0) begin
      failCount++; $display("[TB] FAIL back_to_back_stale got %0d lit 1-digits want 0", seenOnes);
    end
    for (int k = 0; k < ND; k++) begin
      testsRun++;
      if (obs[k] !== 7'h24) begin
        failCount++; $display("[TB] FAIL back_to_back_digit%0d got %h want 24", k, obs[k]);
      end
    end
  endtask

  task automatic test_boundary_load();
    logic [6:0] obs [ND];
    int         loadFrame = -10;
    bit         done = 0;
    bit         doLoad;
    for (int k = 0; k < ND; k++) obs[k] = 'x;
    for (int c = 0; c < 4 * FRAME; c++) begin
      doLoad = !done && (t % FRAME == FRAME - 1) && c > FRAME / 2;
      if (doLoad) begin done = 1; loadFrame = t / FRAME; end
      tick(doLoad, 16'h8888, 4'b0000, 4'b0000, 0);
      testsRun++;
      if (an_n !== expAn() || seg_n !== expSeg || dp_n !== expDp || frame_done !== expFd()) begin
        failCount++;
        $display("[TB] FAIL boundary_load t=%0d got an=%b seg=%h dp=%b fd=%b want an=%b seg=%h dp=%b fd=%b",
                 t, an_n, seg_n, dp_n, frame_done, expAn(), expSeg, expDp, expFd());
      end
      if (t / FRAME == loadFrame + 1 && t % RD == 4) obs[(t / RD) % ND] = seg_n;
    end
    for (int k = 0; k < ND; k++) begin
      testsRun++;
      if (obs[k] !== 7'h00) begin
        failCount++; $display("[TB] FAIL boundary_load_digit%0d got %h want 00", k, obs[k]);
      end
    end
  endtask

  task automatic test_random();
    bit          doLoad;
    logic [15:0] dig;
    logic [3:0]  dp, bl;
    bit          lz;
    for (int c = 0; c < 12 * FRAME; c++) begin
      doLoad = ($urandom_range(0, 15) == 0) ||
               ((t % FRAME == FRAME - 1) && ($urandom_range(0, 2) == 0));
      dig = ($urandom_range(0, 1) == 0) ? 16'($urandom()) : 16'($urandom_range(0, 255));
      dp  = 4'($urandom_range(0, 15));
      bl  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      lz  = 1'($urandom_range(0, 1));
      tick(doLoad, dig, dp, bl, lz);
      testsRun++;
      if (an_n !== expAn() || seg_n !== expSeg || dp_n !== expDp || frame_done !== expFd()) begin
        failCount++;
        $display("[TB] FAIL random t=%0d got an=%b seg=%h dp=%b fd=%b want an=%b seg=%h dp=%b fd=%b",
                 t, an_n, seg_n, dp_n, frame_done, expAn(), expSeg, expDp, expFd());
      end
    end
  endtask

  task automatic test_reset_midframe();
    int seenThrees = 0;
    for (int c = 0; c < 2 * FRAME && t % FRAME != 3; c++) tick(0, '0, '0, '0, 0);
    tick(1, 16'h3333, 4'b1111, 4'b0000, 0);
    repeat (6) tick(0, '0, '0, '0, 0);
    #2 rst_n = 1'b0;
    #1;
    testsRun++;
    if (an_n !== 4'hF || seg_n !== 7'h7F || dp_n !== 1'b1 || frame_done !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL reset_midframe got an=%b seg=%h dp=%b fd=%b want an=1111 seg=7f dp=1 fd=0",
               an_n, seg_n, dp_n, frame_done);
    end
    resetModel();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3 * FRAME; c++) begin
      tick(0, '0, '0, '0, 0);
      testsRun++;
      if (an_n !== expAn() || seg_n !== expSeg || dp_n !== expDp || frame_done !== expFd()) begin
        failCount++;
        $display("[TB] FAIL reset_restart t=%0d got an=%b seg=%h dp=%b fd=%b want an=%b seg=%h dp=%b fd=%b",
                 t, an_n, seg_n, dp_n, frame_done, expAn(), expSeg, expDp, expFd());
      end
      if (seg_n === 7'h30 || dp_n === 1'b0) seenThrees++;
    end
    testsRun++;
    if (seenThrees !== 0) begin
      failCount++; $display("[TB] FAIL reset_discard got %0d stale cycles want 0", seenThrees);
    end
  endtask

  initial begin
    test_reset();
    test_scan_idle();
    test_load_hex();
    test_lz();
    test_back_to_back();
    test_boundary_load();
    test_random();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/seven_seg_mux.md
SEVEN_SEG_MUX -- requirements
Module: seven_seg_mux

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4: digits scanned, range 1..8.
REQ-002 SHALL have parameter REFRESH_DIV, default 100000: clk cycles per digit slot, minimum 4.
REQ-003 SHALL have parameter DEAD_CYCLES, default 16: all-anodes-off cycles at the start of each slot; must be less than REFRESH_DIV.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port digits_in, input, 4*NUM_DIGITS: hex nibbles; nibble i drives digit i, digit 0 is least significant.
REQ-007 SHALL have port dp_in, input, NUM_DIGITS: decimal-point enable per digit, 1 = lit.
REQ-008 SHALL have port blank_in, input, NUM_DIGITS: forced blank per digit, 1 = dark.
REQ-009 SHALL have port lz_en, input, 1: leading-zero suppression enable, sampled with load.
REQ-010 SHALL have port load, input, 1: one-cycle strobe capturing digits_in, dp_in, blank_in and lz_en.
REQ-011 SHALL have port seg_n, output, 7: segments g..a (bit 6 = g, bit 0 = a), active-low.
REQ-012 SHALL have port dp_n, output, 1: decimal point, active-low.
REQ-013 SHALL have port an_n, output, NUM_DIGITS: digit anodes, active-low, one-hot-low or all high.
REQ-014 SHALL have port frame_done, output, 1: one-cycle pulse when digit NUM_DIGITS-1 slot ends.

Function
REQ-015 A prescaler SHALL count 0..REFRESH_DIV-1 and wrap; the slot ends on the wrap cycle.
REQ-016 A digit index SHALL advance on each slot end, wrapping from NUM_DIGITS-1 to 0; frame boundary = slot end with index NUM_DIGITS-1.
REQ-017 While prescaler < DEAD_CYCLES, an_n SHALL be all ones; otherwise only an_n[index] SHALL be 0.
REQ-018 seg_n/dp_n SHALL be registered and SHALL reflect the current index's digit, with one-cycle latency from prescaler and index.
REQ-019 Decode SHALL be the standard hex font (0-9, A b C d E F); active-high codes are inverted to seg_n.
REQ-020 On load, a shadow register SHALL capture all inputs and set a pending flag.
REQ-021 At a frame boundary with pending set, the active register SHALL copy the shadow and pending SHALL clear, so no frame shows mixed old/new digits.
REQ-022 A load on the frame-boundary cycle SHALL bypass the shadow: active takes the inputs directly and pending stays clear.
REQ-023 Back-to-back loads within a frame SHALL keep only the last one; nothing is queued.
REQ-024 Update latency from load to display SHALL be at most NUM_DIGITS*REFRESH_DIV+1 cycles.
REQ-025 With lz_en active, every zero digit above the most significant non-zero digit SHALL be blanked; digit 0 is never suppressed.
REQ-026 A blanked digit (blank_in or lz suppression) SHALL drive seg_n all ones; dp_n SHALL still follow dp_in.
REQ-027 NUM_DIGITS=1 SHALL have every slot end be a frame boundary.

Reset
REQ-028 While rst_n=0: prescaler=0, index=0, shadow=0, active=0, pending=0.
REQ-029 While rst_n=0: an_n all ones, seg_n=7'h7F, dp_n=1, frame_done=0.
REQ-030 Reset mid-frame SHALL discard any pending load; scanning restarts at digit 0 with a dead period.

Structure
REQ-031 Package seven_seg_pkg SHALL hold the 16-entry font constants and segment bit indices.
REQ-032 Sub-module seven_seg_decode SHALL be a combinational nibble-to-active-high-segment decoder, instantiated once on the selected nibble.

Verification (bench uses NUM_DIGITS=4, REFRESH_DIV=8, DEAD_CYCLES=2)
REQ-033 Reset release with no load -> an_n cycles 1110,1101,1011,0111 with 2 all-high cycles per slot; seg_n=7'h40 (digit 0) on every digit.
REQ-034 load with digits_in=16'h12AF, dp_in=4'b0100 -> after next frame boundary: digit0 seg_n=7'h0E (F), digit1 seg_n=7'h08 (A), digit2 seg_n=7'h24 with dp_n=0, digit3 seg_n=7'h79.
REQ-035 load 16'h0070 with lz_en=1 -> digit3 and digit2 seg_n=7'h7F, digit1=7'h78, digit0=7'h40.
REQ-036 load 16'h1111, then load 16'h2222 mid-frame before the boundary -> 1111 is never displayed; 2222 appears intact in one frame.
REQ-037 load 16'h8888 on the frame-boundary cycle -> the next frame shows seg_n=7'h00 on all digits; pending stays 0.
REQ-038 Assert rst_n=0 mid-slot after a load -> outputs take reset values immediately; after release, digits show 0, not the pending value.
